// File: rtl/memory_responder.sv
// memory_responder: CPU memory bus responder splitting RAM (<0xFF00) from an I/O page (switches, LEDs, draw FIFO).
// Optional timer/compare/status at 0xFF03-0xFF05 built when MEMORY_RESPONDER_TIMER_EN is defined.
module memory_responder (
  input  logic        clock,
  input  logic        reset,
  input  logic        memory_write_enable,
  input  logic [15:0] memory_address,
  input  logic [15:0] memory_write_data,
  output logic [15:0] memory_read_data,
  output logic [15:0] ram_address,
  output logic [15:0] ram_write_data,
  output logic        ram_write_enable,
  input  logic [15:0] ram_read_data,
  input  logic [9:0]  switches,
  output logic [9:0]  leds,
  output logic [15:0] draw_data,
  output logic        draw_valid,
  input  logic        draw_ready
);
  logic        io_sel;
  logic [7:0]  off;
  logic        wr_led, wr_draw, rd_draw;
  logic [9:0]  sw_meta_q, sw_sync_q, leds_q;
  logic [15:0] fifo_q [4];
  logic [1:0]  wptr_q, rptr_q;
  logic [2:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        pop, push, full, drop;
  logic        sel_io_q, valid_q;
  logic [15:0] io_rdata_q, io_rdata_d, timer_rdata;

  assign io_sel           = memory_address[15:8] == 8'hFF;
  assign off              = memory_address[7:0];
  assign ram_address      = memory_address;
  assign ram_write_data   = memory_write_data;
  assign ram_write_enable = memory_write_enable && !io_sel;
  assign wr_led           = memory_write_enable && io_sel && off == 8'h01;
  assign wr_draw          = memory_write_enable && io_sel && off == 8'h02;
  assign rd_draw          = !memory_write_enable && io_sel && off == 8'h02;

  assign full       = count_q == 3'd4;
  assign draw_valid = count_q != 3'd0;
  assign draw_data  = fifo_q[rptr_q];
  assign leds       = leds_q;
  assign pop        = draw_valid && draw_ready;
  assign push       = wr_draw && (!full || pop);
  assign drop       = wr_draw && full && !pop;

`ifdef MEMORY_RESPONDER_TIMER_EN
  logic [15:0] cnt_q, cmp_q;
  logic        match_q, match_d;
  assign match_d     = (cnt_q == cmp_q) ||
                       (match_q && !(memory_write_enable && io_sel && off == 8'h05 && memory_write_data[0]));
  assign timer_rdata = off == 8'h03 ? cnt_q :
                       off == 8'h04 ? cmp_q :
                       off == 8'h05 ? {15'b0, match_q} : 16'h0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= 16'h0;
      cmp_q   <= 16'hFFFF;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= (memory_write_enable && io_sel && off == 8'h03) ? 16'h0 : cnt_q + 16'h1;
      match_q <= match_d;
      if (memory_write_enable && io_sel && off == 8'h04) cmp_q <= memory_write_data;
    end
  end
`else
  assign timer_rdata = 16'h0;
`endif

  always_comb begin
    count_d    = count_q + {2'b0, push} - {2'b0, pop};
    ovf_d      = drop ? 1'b1 : (rd_draw ? 1'b0 : ovf_q);
    io_rdata_d = off == 8'h00 ? {6'b0, sw_sync_q} :
                 off == 8'h01 ? {6'b0, leds_q} :
                 off == 8'h02 ? {ovf_q, 12'b0, count_q} : timer_rdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      leds_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      sel_io_q   <= 1'b0;
      valid_q    <= 1'b0;
      io_rdata_q <= '0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else begin
      sw_meta_q  <= switches;
      sw_sync_q  <= sw_meta_q;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      sel_io_q   <= io_sel;
      valid_q    <= 1'b1;
      io_rdata_q <= io_rdata_d;
      if (wr_led) leds_q <= memory_write_data[9:0];
      if (push) begin
        fifo_q[wptr_q] <= memory_write_data;
        wptr_q         <= wptr_q + 2'd1;
      end
      if (pop) rptr_q <= rptr_q + 2'd1;
    end
  end

  // valid_q forces zero read data until the first edge after reset, independent of the RAM output
  assign memory_read_data = valid_q ? (sel_io_q ? io_rdata_q : ram_read_data) : 16'h0;
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed + random checks of memory_responder against a queue-based reference model.
module tb_memory_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        memory_write_enable = 1'b0;
  logic [15:0] memory_address = '0, memory_write_data = '0;
  logic [15:0] memory_read_data, ram_address, ram_write_data, ram_read_data;
  logic        ram_write_enable;
  logic [9:0]  switches = '0, leds;
  logic [15:0] draw_data;
  logic        draw_valid;
  logic        draw_ready = 1'b0;

  int checks = 0, errors = 0;

  logic [15:0] tram [256];
  logic [15:0] mram [256];
  logic [15:0] mq [$];
  logic [9:0]  m_leds, m_sw1, m_sw2;
  logic        m_ovf, m_match;
  logic [15:0] m_cnt, m_cmp, exp_rd;

  memory_responder dut (
    .clock(clock), .reset(reset), .memory_write_enable(memory_write_enable),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .memory_read_data(memory_read_data), .ram_address(ram_address),
    .ram_write_data(ram_write_data), .ram_write_enable(ram_write_enable),
    .ram_read_data(ram_read_data), .switches(switches), .leds(leds),
    .draw_data(draw_data), .draw_valid(draw_valid), .draw_ready(draw_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_write_enable) tram[ram_address[7:0]] <= ram_write_data;
    ram_read_data <= tram[ram_address[7:0]];
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    mq.delete();
    m_leds = '0; m_sw1 = '0; m_sw2 = '0; m_ovf = 1'b0;
    m_cnt = '0; m_cmp = 16'hFFFF; m_match = 1'b0; exp_rd = '0;
  endtask

  function automatic logic [15:0] io_read(input logic [15:0] a);
    case (a[7:0])
      8'h00: return {6'b0, m_sw2};
      8'h01: return {6'b0, m_leds};
      8'h02: return {m_ovf, 12'b0, 3'(mq.size())};
`ifdef MEMORY_RESPONDER_TIMER_EN
      8'h03: return m_cnt;
      8'h04: return m_cmp;
      8'h05: return {15'b0, m_match};
`endif
      default: return 16'h0;
    endcase
  endfunction

  // Drive one bus cycle from a negedge, advance the model across the posedge, check at the next negedge.
  task automatic step(input bit we, input logic [15:0] a, input logic [15:0] d, input bit rdy);
    bit pop, preq, full, io;
    memory_write_enable = we; memory_address = a; memory_write_data = d; draw_ready = rdy;
    #1;
    io = a >= 16'hFF00;
    check("ram_we", {15'b0, ram_write_enable}, {15'b0, we && !io});
    check("ram_addr", ram_address, a);
    exp_rd = io ? io_read(a) : mram[a[7:0]];
    pop  = mq.size() != 0 && rdy;
    preq = we && a == 16'hFF02;
    full = mq.size() == 4;
    if (!we && a == 16'hFF02) m_ovf = 1'b0;
    if (preq && full && !pop) m_ovf = 1'b1;
    if (pop) void'(mq.pop_front());
    if (preq && (!full || pop)) mq.push_back(d);
    if (we && a == 16'hFF01) m_leds = d[9:0];
    if (we && !io) mram[a[7:0]] = d;
    m_sw2 = m_sw1; m_sw1 = switches;
`ifdef MEMORY_RESPONDER_TIMER_EN
    m_match = (m_cnt == m_cmp) || (m_match && !(we && a == 16'hFF05 && d[0]));
    if (we && a == 16'hFF04) m_cmp = d;
    m_cnt = (we && a == 16'hFF03) ? 16'h0 : m_cnt + 16'h1;
`endif
    @(negedge clock);
    check("rdata", memory_read_data, exp_rd);
    check("valid", {15'b0, draw_valid}, {15'b0, mq.size() != 0});
    if (mq.size() != 0) check("head", draw_data, mq[0]);
    check("leds", {6'b0, leds}, {6'b0, m_leds});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin tram[i] = '0; mram[i] = '0; end
    mreset();
    repeat (2) @(negedge clock);
    check("rst_rdata", memory_read_data, 16'h0);
    check("rst_valid", {15'b0, draw_valid}, 16'h0);
    check("rst_data", draw_data, 16'h0);
    check("rst_leds", {6'b0, leds}, 16'h0);
    reset = 1'b0;

    step(1, 16'h0040, 16'h1234, 0);
    step(0, 16'h0040, 16'h0, 0);
    check("ram_read", memory_read_data, 16'h1234);

    step(1, 16'hFF01, 16'h03FF, 0);
    check("led_write", {6'b0, leds}, 16'h03FF);
    step(1, 16'hFF00, 16'hFFFF, 0);
    step(0, 16'hFF01, 16'h0, 0);
    check("led_read", memory_read_data, 16'h03FF);

    switches = 10'h2A5;
    step(0, 16'h0000, 16'h0, 0);
    step(0, 16'h0000, 16'h0, 0);
    step(0, 16'hFF00, 16'h0, 0);
    check("sw_read", memory_read_data, 16'h02A5);

    for (int i = 0; i < 5; i++) step(1, 16'hFF02, 16'hA1 + 16'(i), 0);
    step(0, 16'hFF02, 16'h0, 0);
    check("stat_ovf", memory_read_data, 16'h8004);
    step(0, 16'hFF02, 16'h0, 0);
    check("stat_clr", memory_read_data, 16'h0004);
    for (int i = 0; i < 4; i++) begin
      check("drain", draw_data, 16'hA1 + 16'(i));
      step(0, 16'h0000, 16'h0, 1);
    end
    check("drained", {15'b0, draw_valid}, 16'h0);

    for (int i = 0; i < 4; i++) step(1, 16'hFF02, 16'hB1 + 16'(i), 0);
    step(1, 16'hFF02, 16'hB5, 1);
    step(0, 16'hFF02, 16'h0, 0);
    check("full_pushpop", memory_read_data, 16'h0004);
    check("full_head", draw_data, 16'hB2);

`ifdef MEMORY_RESPONDER_TIMER_EN
    step(1, 16'hFF04, 16'h0005, 0);
    step(1, 16'hFF03, 16'h0, 0);
    repeat (8) step(0, 16'h0000, 16'h0, 0);
    step(0, 16'hFF05, 16'h0, 0);
    check("tmatch", memory_read_data, 16'h0001);
    step(1, 16'hFF05, 16'h0001, 0);
    step(0, 16'hFF05, 16'h0, 0);
    check("tmatch_clr", memory_read_data, 16'h0000);
    step(1, 16'hFF03, 16'h0, 0);
    repeat (65535) step(0, 16'h0000, 16'h0, 0);
    step(0, 16'hFF03, 16'h0, 0);
    check("tmax", memory_read_data, 16'hFFFF);
    step(0, 16'hFF03, 16'h0, 0);
    check("twrap", memory_read_data, 16'h0000);
`else
    step(1, 16'hFF03, 16'h1234, 0);
    step(0, 16'hFF03, 16'h0, 0);
    check("no_timer", memory_read_data, 16'h0000);
`endif

    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", {15'b0, draw_valid}, 16'h0);
    check("mid_rst_rdata", memory_read_data, 16'h0);
    check("mid_rst_leds", {6'b0, leds}, 16'h0);
    mreset();
    @(negedge clock);
    reset = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a;
      a = $urandom_range(0, 1) ? 16'($urandom_range(0, 15)) : 16'hFF00 + 16'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) switches = 10'($urandom);
      step(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
